pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
// - Parametrised inter-stage pipeline register; generic successor of the fixed-field EXE/MEM latch.
// - Carries one packed DATA_W payload between two pipeline stages, with a valid bit.
// - MODE 0: legacy stall-vector/flush semantics, including bubble insertion.
// - MODE 1: elastic valid/ready stage with a 2-entry skid buffer, for decoupled (e.g. cache/AXI) stages.
// PARAMETERS
// - DATA_W     32*8   packed payload width (aluop, wa, wd, pc, exccode ... concatenated by instantiator)
// - STALL_W    6      width of the global stall vector
// - STAGE_IDX  3      stall bit owned by the upstream stage of this register; bubble test uses STAGE_IDX+1
// - MODE       0      0 = stall-vector mode, 1 = valid/ready skid mode
// - NOP_DATA   '0     payload driven whenever out_valid=0; instantiator packs SLL/REG_NOP/PC_INIT/EXC_NONE here
// PORTS
// - cpu_clk_50M  in   1        clock, all state on rising edge
// - cpu_rst      in   1        synchronous reset, active-high
// - stall        in   STALL_W  global stall vector, 1 = STOP (MODE 0 only)
// - flush        in   1        exception/eret flush, kills all held and incoming entries
// - in_valid     in   1        upstream payload valid
// - in_data      in   DATA_W   upstream payload
// - in_ready     out  1        stage accepts in_data this cycle
// - out_valid    out  1        downstream payload valid
// - out_data     out  DATA_W   downstream payload (NOP_DATA when out_valid=0)
// - out_ready    in   1        downstream accepts (MODE 1 only; ignored in MODE 0)
// - perf_clr     in   1        clear performance counters
// - perf_stall   out  32       cycles a valid entry was held
// - perf_bubble  out  32       bubbles inserted (MODE 0) / cycles out_valid=0 while in_valid=0 (MODE 1)
// - perf_flush   out  32       flush events that killed >=1 valid entry
// BEHAVIOUR
// - Reset (cpu_rst=1 at edge): out_valid=0, out_data=NOP_DATA, skid empty, counters 0; in_ready=0 in the reset cycle.
// - Priority at every edge: cpu_rst > flush > mode logic. Flush: out_valid<=0, out_data<=NOP_DATA, skid emptied,
//   input in the same cycle discarded even if in_valid&in_ready; in_ready=1 from the next cycle.
// - out_data registered; out_valid=0 always implies out_data==NOP_DATA (no stale payload leaks).
// - MODE 0 (S=STAGE_IDX, N=stall[S+1], N=0 if S==STALL_W-1):
//   - stall[S]=1 & N=0 -> bubble: out_valid<=0, out_data<=NOP_DATA.
//   - stall[S]=0        -> load: out_valid<=in_valid, out_data<=in_valid ? in_data : NOP_DATA.
//   - stall[S]=1 & N=1  -> hold all state.
//   - in_ready = ~stall[S] (combinational); latency 1 cycle; skid unused.
// - MODE 1 states: EMPTY (no entry), ONE (main reg valid), FULL (main + skid valid).
//   - in_ready = (state!=FULL), registered; accept = in_valid&in_ready; send = out_valid&out_ready.
//   - EMPTY: accept -> ONE.  ONE: accept&~send -> FULL (data to skid); accept&send -> ONE (main<=in);
//     ~accept&send -> EMPTY.  FULL: send -> ONE (main<=skid); accept impossible.
//   - Latency 1 cycle; sustained throughput 1/cycle; strict FIFO order; no duplication or loss.
//   - stall ignored. Reset/flush mid-handshake: entry dropped, upstream must re-present.
// CONFIGURATION
// - PIPE_STAGE_PERF_EN defined: three 32-bit saturating counters (stick at 32'hFFFF_FFFF);
//   perf_clr zeroes them next edge, increment in the same cycle lost; cpu_rst zeroes them.
//   stall counts: MODE 0 stall[S]&N&out_valid; MODE 1 out_valid&~out_ready.
// - Not defined: counter logic omitted; perf_* ports remain and are tied to 0.
// TESTING
// - Reset: assert cpu_rst 2 cycles with in_valid=1 -> out_valid=0, out_data=NOP_DATA, perf_*=0.
// - MODE 0 load/hold/bubble: in_data=A, stall=0 -> out=A next cycle; stall=6'b011000 -> A held;
//   stall=6'b001000 -> out_valid=0, out_data=NOP_DATA, perf_bubble=1.
// - Flush priority: stall=6'b001000 and flush=1 with in_valid=1 -> out_valid=0, perf_flush+1 only if prior entry valid.
// - MODE 1 backpressure: stream A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0, C held upstream;
//   out_ready=1 -> A,B,C emerge in order on consecutive cycles.
// - MODE 1 full-rate: in_valid=out_ready=1 for 100 cycles -> 100 transfers, in_ready never drops.
// - Saturation (PIPE_STAGE_PERF_EN): force perf_stall to 32'hFFFF_FFFE, hold 3 cycles -> 32'hFFFF_FFFF; perf_clr -> 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: MODE 0 stall-vector latch (1 cycle, in_ready=~stall[S]) or MODE 1 valid/ready stage with 2-entry skid (1 cycle, full rate).
// Optional saturating performance counters are built when PIPE_STAGE_PERF_EN is defined; otherwise perf_* read 0.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32*8,
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 3,
    parameter int                MODE      = 0,
    parameter logic [DATA_W-1:0] NOP_DATA  = '0
) (
    input  logic               i_cpu_clk_50M,
    input  logic               i_cpu_rst,
    input  logic [STALL_W-1:0] i_stall,
    input  logic               i_flush,
    input  logic               i_in_valid,
    input  logic [DATA_W-1:0]  i_in_data,
    output logic               o_in_ready,
    output logic               o_out_valid,
    output logic [DATA_W-1:0]  o_out_data,
    input  logic               i_out_ready,
    input  logic               i_perf_clr,
    output logic [31:0]        o_perf_stall,
    output logic [31:0]        o_perf_bubble,
    output logic [31:0]        o_perf_flush
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t            r_state, w_nxt_state;
    logic              r_out_valid, w_nxt_valid;
    logic [DATA_W-1:0] r_out_data, w_nxt_data;
    logic [DATA_W-1:0] r_skid_data, w_nxt_skid;
    logic              r_in_ready, w_nxt_in_ready;

    logic [STALL_W:0]  w_stall_ext;
    logic              w_s, w_n, w_accept, w_send, w_unused;

    // Top stall bit has no downstream owner, so the extension bit reads as 0.
    assign w_stall_ext = {1'b0, i_stall};
    assign w_s         = w_stall_ext[STAGE_IDX];
    assign w_n         = w_stall_ext[STAGE_IDX+1];
    assign w_unused    = ^{i_stall, i_perf_clr};

    assign o_in_ready  = (MODE == 0) ? (~w_s & ~i_cpu_rst) : (r_in_ready & ~i_cpu_rst);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_send      = r_out_valid & i_out_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_valid    = r_out_valid;
        w_nxt_data     = r_out_data;
        w_nxt_skid     = r_skid_data;
        w_nxt_in_ready = r_in_ready;
        if (MODE == 0) begin
            w_nxt_state = ST_EMPTY;
            if (!w_s) begin
                w_nxt_valid = i_in_valid;
                w_nxt_data  = i_in_valid ? i_in_data : NOP_DATA;
            end else if (!w_n) begin
                w_nxt_valid = 1'b0;
                w_nxt_data  = NOP_DATA;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_nxt_state = ST_ONE;
                        w_nxt_valid = 1'b1;
                        w_nxt_data  = i_in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_send) begin
                        w_nxt_state = ST_FULL;
                        w_nxt_skid  = i_in_data;
                    end else if (w_accept && w_send) begin
                        w_nxt_data  = i_in_data;
                    end else if (w_send) begin
                        w_nxt_state = ST_EMPTY;
                        w_nxt_valid = 1'b0;
                        w_nxt_data  = NOP_DATA;
                    end
                end
                ST_FULL: begin
                    if (w_send) begin
                        w_nxt_state = ST_ONE;
                        w_nxt_data  = r_skid_data;
                    end
                end
                default: begin
                    w_nxt_state = ST_EMPTY;
                    w_nxt_valid = 1'b0;
                    w_nxt_data  = NOP_DATA;
                end
            endcase
            w_nxt_in_ready = (w_nxt_state != ST_FULL);
        end
    end

    always_ff @(posedge i_cpu_clk_50M) begin
        if (i_cpu_rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_DATA;
            r_skid_data <= NOP_DATA;
            r_in_ready  <= 1'b0;
        end else if (i_flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_DATA;
            r_skid_data <= NOP_DATA;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_out_valid <= w_nxt_valid;
            r_out_data  <= w_nxt_data;
            r_skid_data <= w_nxt_skid;
            r_in_ready  <= w_nxt_in_ready;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_perf_stall, r_perf_bubble, r_perf_flush;
    logic        w_inc_stall, w_inc_bubble, w_inc_flush;

    // Skid entry can only exist alongside a valid main entry, so r_out_valid covers both.
    assign w_inc_stall  = ~i_flush & r_out_valid & ((MODE == 0) ? (w_s & w_n) : ~i_out_ready);
    assign w_inc_bubble = ~i_flush & ((MODE == 0) ? (w_s & ~w_n) : (~r_out_valid & ~i_in_valid));
    assign w_inc_flush  = i_flush & r_out_valid;

    always_ff @(posedge i_cpu_clk_50M) begin
        if (i_cpu_rst || i_perf_clr) begin
            r_perf_stall  <= 32'd0;
            r_perf_bubble <= 32'd0;
            r_perf_flush  <= 32'd0;
        end else begin
            if (w_inc_stall  && !(&r_perf_stall))  r_perf_stall  <= r_perf_stall  + 32'd1;
            if (w_inc_bubble && !(&r_perf_bubble)) r_perf_bubble <= r_perf_bubble + 32'd1;
            if (w_inc_flush  && !(&r_perf_flush))  r_perf_flush  <= r_perf_flush  + 32'd1;
        end
    end

    assign o_perf_stall  = r_perf_stall;
    assign o_perf_bubble = r_perf_bubble;
    assign o_perf_flush  = r_perf_flush;
`else
    assign o_perf_stall  = 32'd0;
    assign o_perf_bubble = 32'd0;
    assign o_perf_flush  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one MODE 0 and one MODE 1 instance run side by side against a queue/rule model.
module tb_pipe_stage_reg;
    localparam logic [15:0] NOP = 16'hDEAD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, perf_clr;
    logic [5:0]  m0_stall, m1_stall;
    logic        m0_flush, m0_iv, m0_ir, m0_ov, m0_ordy;
    logic        m1_flush, m1_iv, m1_ir, m1_ov, m1_ordy;
    logic [15:0] m0_id, m0_od, m1_id, m1_od;
    logic [31:0] m0_ps, m0_pb, m0_pf, m1_ps, m1_pb, m1_pf;

    pipe_stage_reg #(.DATA_W(16), .STALL_W(6), .STAGE_IDX(3), .MODE(0), .NOP_DATA(NOP)) dut0 (
        .i_cpu_clk_50M(clk), .i_cpu_rst(rst), .i_stall(m0_stall), .i_flush(m0_flush),
        .i_in_valid(m0_iv), .i_in_data(m0_id), .o_in_ready(m0_ir), .o_out_valid(m0_ov),
        .o_out_data(m0_od), .i_out_ready(m0_ordy), .i_perf_clr(perf_clr),
        .o_perf_stall(m0_ps), .o_perf_bubble(m0_pb), .o_perf_flush(m0_pf));

    pipe_stage_reg #(.DATA_W(16), .STALL_W(6), .STAGE_IDX(3), .MODE(1), .NOP_DATA(NOP)) dut1 (
        .i_cpu_clk_50M(clk), .i_cpu_rst(rst), .i_stall(m1_stall), .i_flush(m1_flush),
        .i_in_valid(m1_iv), .i_in_data(m1_id), .o_in_ready(m1_ir), .o_out_valid(m1_ov),
        .o_out_data(m1_od), .i_out_ready(m1_ordy), .i_perf_clr(perf_clr),
        .o_perf_stall(m1_ps), .o_perf_bubble(m1_pb), .o_perf_flush(m1_pf));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: MODE 0 is a single slot, MODE 1 a queue of at most two entries.
    logic        e0_v;
    logic [15:0] e0_d;
    logic [31:0] e0_ps, e0_pb, e0_pf;
    logic [15:0] q1[$];
    logic        e1_rdy;
    logic [31:0] e1_ps, e1_pb, e1_pf;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        iv;
        logic [15:0] id;
        logic        rdy;
        logic        ov;
        logic [15:0] od;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    function automatic logic [31:0] pexp(input logic [31:0] c);
`ifdef PIPE_STAGE_PERF_EN
        return c;
`else
        return (c & 32'd0);
`endif
    endfunction

    // One clock: check in_ready, advance the model on pre-edge inputs, compare registered outputs.
    task automatic step();
        logic s, n, snd, acc, fl;
        #1;
        chk("m0_in_ready", {31'd0, m0_ir}, rst ? 32'd0 : {31'd0, ~m0_stall[3]});
        chk("m1_in_ready", {31'd0, m1_ir}, rst ? 32'd0 : {31'd0, e1_rdy});
        s = m0_stall[3];
        n = m0_stall[4];
        fl = m0_flush;
        if (rst) begin
            e0_v = 1'b0; e0_d = NOP; e0_ps = 0; e0_pb = 0; e0_pf = 0;
        end else begin
            if (perf_clr) begin
                e0_ps = 0; e0_pb = 0; e0_pf = 0;
            end else begin
                if (fl && e0_v)            e0_pf = sat(e0_pf);
                if (!fl && s && n && e0_v) e0_ps = sat(e0_ps);
                if (!fl && s && !n)        e0_pb = sat(e0_pb);
            end
            if (fl) begin
                e0_v = 1'b0; e0_d = NOP;
            end else if (!s) begin
                e0_v = m0_iv; e0_d = m0_iv ? m0_id : NOP;
            end else if (!n) begin
                e0_v = 1'b0; e0_d = NOP;
            end
        end
        fl = m1_flush;
        if (rst) begin
            q1.delete(); e1_rdy = 1'b0; e1_ps = 0; e1_pb = 0; e1_pf = 0;
        end else begin
            snd = (q1.size() > 0) && m1_ordy;
            acc = m1_iv && e1_rdy;
            if (perf_clr) begin
                e1_ps = 0; e1_pb = 0; e1_pf = 0;
            end else begin
                if (fl && q1.size() > 0)               e1_pf = sat(e1_pf);
                if (!fl && q1.size() > 0 && !m1_ordy)  e1_ps = sat(e1_ps);
                if (!fl && q1.size() == 0 && !m1_iv)   e1_pb = sat(e1_pb);
            end
            if (fl) q1.delete();
            else begin
                if (snd) void'(q1.pop_front());
                if (acc) q1.push_back(m1_id);
            end
            e1_rdy = (q1.size() < 2);
        end
        @(posedge clk);
        #1;
        chk("m0_out_valid", {31'd0, m0_ov}, {31'd0, e0_v});
        chk("m0_out_data", {16'd0, m0_od}, {16'd0, e0_d});
        chk("m0_perf_stall", m0_ps, pexp(e0_ps));
        chk("m0_perf_bubble", m0_pb, pexp(e0_pb));
        chk("m0_perf_flush", m0_pf, pexp(e0_pf));
        chk("m1_out_valid", {31'd0, m1_ov}, {31'd0, q1.size() > 0});
        chk("m1_out_data", {16'd0, m1_od}, {16'd0, (q1.size() > 0) ? q1[0] : NOP});
        chk("m1_perf_stall", m1_ps, pexp(e1_ps));
        chk("m1_perf_bubble", m1_pb, pexp(e1_pb));
        chk("m1_perf_flush", m1_pf, pexp(e1_pf));
    endtask

    initial begin
        int sends, drops, nxt;
        tbl[0]  = '{6'b000000, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 16'h1111};
        tbl[1]  = '{6'b011000, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h1111};
        tbl[2]  = '{6'b011000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1111};
        tbl[3]  = '{6'b001000, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 16'hDEAD};
        tbl[4]  = '{6'b000000, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0, 16'hDEAD};
        tbl[5]  = '{6'b010000, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 16'h5555};
        tbl[6]  = '{6'b000000, 1'b0, 1'b1, 16'h6666, 1'b1, 1'b1, 16'h6666};
        tbl[7]  = '{6'b011000, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 16'hDEAD};
        tbl[8]  = '{6'b000000, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b1, 16'h8888};
        tbl[9]  = '{6'b100000, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b1, 16'h9999};
        tbl[10] = '{6'b001000, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'hDEAD};
        tbl[11] = '{6'b011000, 1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b0, 16'hDEAD};
        tbl[12] = '{6'b001000, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, 16'hDEAD};

        rst = 1'b1; perf_clr = 1'b0;
        m0_stall = '0; m0_flush = 1'b0; m0_iv = 1'b1; m0_id = 16'h1234; m0_ordy = 1'b0;
        m1_stall = '0; m1_flush = 1'b0; m1_iv = 1'b1; m1_id = 16'h5678; m1_ordy = 1'b0;
        e0_v = 1'b0; e0_d = NOP; e0_ps = 0; e0_pb = 0; e0_pf = 0;
        e1_rdy = 1'b0; e1_ps = 0; e1_pb = 0; e1_pf = 0;
        step();
        step();
        rst = 1'b0; m0_iv = 1'b0; m1_iv = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            m0_stall = tbl[i].stall; m0_flush = tbl[i].flush;
            m0_iv = tbl[i].iv; m0_id = tbl[i].id;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, m0_ir}, {31'd0, tbl[i].rdy});
            step();
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, m0_ov}, {31'd0, tbl[i].ov});
            chk($sformatf("tbl%0d_out_data", i), {16'd0, m0_od}, {16'd0, tbl[i].od});
        end
        m0_stall = '0; m0_flush = 1'b0; m0_iv = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        chk("tbl_perf_stall", m0_ps, 32'd2);
        chk("tbl_perf_bubble", m0_pb, 32'd2);
        chk("tbl_perf_flush", m0_pf, 32'd1);
`else
        chk("tbl_perf_stall", m0_ps, 32'd0);
        chk("tbl_perf_flush", m0_pf, 32'd0);
`endif

        m1_ordy = 1'b0; m1_iv = 1'b1; m1_id = 16'h00A1;
        step();
        m1_id = 16'h00B2;
        step();
        m1_id = 16'h00C3;
        step();
        step();
        chk("bp_main_a", {16'd0, m1_od}, 32'h00A1);
        chk("bp_in_ready_full", {31'd0, m1_ir}, 32'd0);
        m1_ordy = 1'b1;
        step();
        chk("bp_out_b", {16'd0, m1_od}, 32'h00B2);
        step();
        chk("bp_out_c", {16'd0, m1_od}, 32'h00C3);
        m1_iv = 1'b0;
        step();
        chk("bp_drained_valid", {31'd0, m1_ov}, 32'd0);
        chk("bp_drained_data", {16'd0, m1_od}, 32'h0000DEAD);

        sends = 0; drops = 0; nxt = 0;
        for (int i = 0; i < 102; i++) begin
            m1_iv = (i < 100); m1_id = 16'(i);
            if (i < 100 && !m1_ir) drops++;
            if (m1_ov && m1_ordy) begin
                chk("fr_order", {16'd0, m1_od}, 32'(nxt));
                nxt++;
                sends++;
            end
            step();
        end
        m1_iv = 1'b0;
        chk("fr_transfers", 32'(sends), 32'd100);
        chk("fr_ready_drops", 32'(drops), 32'd0);

`ifdef PIPE_STAGE_PERF_EN
        m1_ordy = 1'b0; m1_iv = 1'b1; m1_id = 16'h0F0F;
        step();
        m1_iv = 1'b0;
        force dut1.r_perf_stall = 32'hFFFF_FFFE;
        #1;
        release dut1.r_perf_stall;
        e1_ps = 32'hFFFF_FFFE;
        step();
        step();
        step();
        chk("sat_stall", m1_ps, 32'hFFFF_FFFF);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("sat_clr", m1_ps, 32'd0);
        m1_ordy = 1'b1;
        step();
`endif

        for (int i = 0; i < 600; i++) begin
            rst      = (i == 300);
            perf_clr = ($urandom_range(0, 63) == 0);
            m0_stall = 6'($urandom);
            m0_flush = ($urandom_range(0, 15) == 0);
            m0_iv    = 1'($urandom);
            m0_id    = 16'($urandom);
            m0_ordy  = 1'($urandom);
            m1_stall = 6'($urandom);
            m1_flush = ($urandom_range(0, 19) == 0);
            m1_iv    = ($urandom_range(0, 3) != 0);
            m1_id    = 16'($urandom);
            m1_ordy  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
